// File: rtl/rcon_seq_pkg.sv
// Shared definitions for the AES round-constant sequencer.
// Holds the key-length mode encodings, sequence lengths, FSM state type and default polynomial.
// No logic of its own; imported by the sequencer and its xtime helper.
package rcon_seq_pkg;

    // Key-length selector as sampled with start
    typedef enum logic [1:0] {
        MODE_128  = 2'b00,
        MODE_192  = 2'b01,
        MODE_256  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    // Number of round constants needed by each key length
    localparam logic [3:0] N_128 = 4'd10;
    localparam logic [3:0] N_192 = 4'd8;
    localparam logic [3:0] N_256 = 4'd7;

    // Sequencer control states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // AES reduction polynomial x^8+x^4+x^3+x+1, low byte only
    localparam logic [7:0] POLY_DEFAULT = 8'h1B;

    // First constant of every sequence
    localparam logic [7:0] RCON_FIRST = 8'h01;

    // Sequence length for a key-length mode; the reserved code behaves as AES-128
    function automatic logic [3:0] seq_len(input mode_e m);
        logic [3:0] n;
        case (m)
            MODE_192: n = N_192;
            MODE_256: n = N_256;
            default:  n = N_128;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rcon_seq_gf_xtime.sv
// GF(2^8) multiply-by-x (xtime) with a configurable reduction polynomial.
// Purely combinational, zero cycles latency.
// No handshake; output follows input continuously.
module gf_xtime
    import rcon_seq_pkg::*;
#(
    parameter logic [7:0] POLY = POLY_DEFAULT
) (
    input  logic [7:0] x_i,
    output logic [7:0] y_o
);

    // Shift left one bit and fold the carried-out x^8 term back in via the polynomial
    always_comb begin
        y_o = {x_i[6:0], 1'b0} ^ (x_i[7] ? POLY : 8'h00);
    end

endmodule

// File: rtl/rcon_seq.sv
// AES key-schedule round-constant sequencer: emits N constants 01, xtime(01), ... per start.
// First constant valid one cycle after start; one constant per accepted transfer thereafter.
// Holds rcon/round_idx/last stable while rcon_ready is low; outputs are registered only.
module rcon_seq
    import rcon_seq_pkg::*;
#(
    parameter logic [7:0] POLY  = POLY_DEFAULT,
    parameter int         IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             rcon_valid,
    input  logic             rcon_ready,
    output logic [7:0]       rcon,
    output logic [IDX_W-1:0] round_idx,
    output logic             last,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       rcon_q, rcon_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    logic             run;
    logic             xfer;
    logic             at_last;
    logic [IDX_W-1:0] n_len;
    logic [7:0]       rcon_nxt;

    // Next constant in the sequence, derived from the one currently presented
    gf_xtime #(
        .POLY (POLY)
    ) u_xtime (
        .x_i (rcon_q),
        .y_o (rcon_nxt)
    );

    // Handshake and end-of-sequence qualifiers, all from registered state
    always_comb begin
        run     = (state_q == ST_RUN);
        n_len   = IDX_W'(seq_len(mode_q));
        at_last = run && (idx_q == n_len);
        xfer    = run && rcon_ready;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start only counts in IDLE; the final accepted constant ends the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)          state_d = ST_RUN;
            ST_RUN:  if (xfer && at_last) state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: every output comes straight from a register, so nothing depends on ready/start
    always_comb begin
        rcon_valid = run;
        busy       = run;
        last       = at_last;
        rcon       = rcon_q;
        round_idx  = idx_q;
        done       = done_q;
    end

    // Datapath next state: load on launch, advance on non-final transfers, otherwise hold
    always_comb begin
        mode_d = mode_q;
        rcon_d = rcon_q;
        idx_d  = idx_q;
        done_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                mode_d = mode_e'(mode);
                rcon_d = RCON_FIRST;
                idx_d  = IDX_W'(1);
            end
        end else if (xfer) begin
            if (at_last) begin
                // Keep the final constant and index visible while idle
                done_d = 1'b1;
            end else begin
                rcon_d = rcon_nxt;
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // Datapath registers; reset clears them and drops any pending done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_128;
            rcon_q <= 8'h00;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
            rcon_q <= rcon_d;
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

endmodule

// File: doc/rcon_seq.md
RCON_SEQ -- requirements
Module: rcon_seq

Interface
REQ-001 Parameter: POLY, default 8'h1B, low byte of the GF(2^8) reduction polynomial used by xtime.
REQ-002 Parameter: IDX_W, default 4, width of round_idx; must satisfy 2^IDX_W > 10.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: start  input  1  request a new round-constant sequence; honoured only in IDLE.
REQ-006 Port: mode  input  2  key length sampled with start: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = reserved.
REQ-007 Port: rcon_valid  output  1  rcon, round_idx and last are valid.
REQ-008 Port: rcon_ready  input  1  consumer accepts the current constant.
REQ-009 Port: rcon  output  8  current round constant.
REQ-010 Port: round_idx  output  IDX_W  1-based index of the current constant.
REQ-011 Port: last  output  1  current constant is the final one for the sampled mode.
REQ-012 Port: busy  output  1  sequence in progress.
REQ-013 Port: done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 FSM states: IDLE and RUN; busy is 1 exactly in RUN.
REQ-015 Transition IDLE->RUN on start: capture mode, load rcon=8'h01 and round_idx=1; rcon_valid is 1 in the following cycle, so latency from start to first valid is one cycle.
REQ-016 Sequence length N: 10 for mode 00 and 11 (11 maps to 128), 8 for mode 01, 7 for mode 10.
REQ-017 rcon_valid is 1 in every RUN cycle and 0 in IDLE.
REQ-018 A transfer occurs when rcon_valid && rcon_ready.
REQ-019 While rcon_ready is 0, rcon, round_idx and last hold stable.
REQ-020 On a non-final transfer, rcon <= xtime(rcon) and round_idx <= round_idx+1 in the next cycle; xtime(x) = {x[6:0],0} XOR (x[7] ? POLY : 0).
REQ-021 With POLY=8'h1B, the full sequence is 01,02,04,08,10,20,40,80,1B,36.
REQ-022 last is 1 iff round_idx == N.
REQ-023 On the transfer with last=1: RUN->IDLE, done=1 in the next cycle only, rcon_valid=0 in the next cycle.
REQ-024 start is ignored while in RUN, including the cycle of the final transfer; mode changes during RUN have no effect.
REQ-025 In IDLE, rcon holds its last value, round_idx holds its last value, and last=0.
REQ-026 A start asserted for several consecutive cycles in IDLE launches exactly one sequence; a new sequence needs start after return to IDLE.
REQ-027 No combinational path exists from rcon_ready or start to any output.

Reset
REQ-028 With rst=1 at a clock edge: state=IDLE, rcon=8'h00, round_idx=0, rcon_valid=0, last=0, busy=0, done=0.
REQ-029 Reset takes priority over start and handshake in the same cycle; reset mid-sequence abandons it without a done pulse.

Structure
REQ-030 A shared package holds the mode encodings, the per-mode N constants, the FSM state typedef and the default POLY.
REQ-031 xtime is a separate combinational sub-module gf_xtime, parametrised by POLY.

Verification
REQ-032 Reset, then start with mode=00 and rcon_ready tied to 1 -> rcon 01,02,04,08,10,20,40,80,1B,36 with idx 1..10 on consecutive cycles; last only with 36; done one cycle later.
REQ-033 mode=01 -> 8 constants ending at 80 with last=1; mode=10 -> 7 constants ending at 40; mode=11 -> same as 00.
REQ-034 rcon_ready toggled randomly -> outputs stable while rcon_valid && !rcon_ready; the sequence is unchanged.
REQ-035 start pulsed, and mode changed, in RUN and in the final-transfer cycle -> ignored; the sequence and N are unaffected.
REQ-036 rst asserted at idx=5 -> next cycle all outputs at reset values and no done; a subsequent start gives a clean sequence from 01.
REQ-037 POLY=8'h1D instance -> after 80 the next constant is 1D, then 3A.
